// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider.
//   div_state_e          : divider FSM state encoding
//   DivStart / DivStop   : levels of the start request from ex
//   DivResultReady / ... : levels of the ready flag back to ex
//   EXE_DIV_OP / ...     : aluop codes that ex decodes into a divide request
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV / DIVU, one quotient bit per clock.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset (highest priority)
//   signed_div_i : 1 = signed divide, 0 = unsigned
//   opdata1_i    : dividend, sampled only when a divide is accepted
//   opdata2_i    : divisor, sampled only when a divide is accepted
//   start_i      : request; ex keeps it high until it has taken the result
//   annul_i      : flush; abandons an in-flight divide
//   result_o     : {remainder, quotient}, non-zero only while ready_o=1
//   ready_o      : result valid
// Latency from the accepting edge: WIDTH+1 edges, or 1 edge for a zero divisor.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    // Upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits shift
    // the dividend out and the quotient in.
    logic [2*WIDTH:0]       work_reg;
    logic [WIDTH-1:0]       divisor_reg;
    logic                   neg_q_reg;
    logic                   neg_r_reg;
    logic [2*WIDTH-1:0]     result_reg;
    logic                   ready_reg;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude, so overflow wraps without a trap.
    logic                   sign1;
    logic                   sign2;
    logic [WIDTH-1:0]       abs1;
    logic [WIDTH-1:0]       abs2;
    assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
    assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1  = sign1 ? -opdata1_i : opdata1_i;
    assign abs2  = sign2 ? -opdata2_i : opdata2_i;

    // One restoring step. The partial remainder is below the divisor, so after
    // the shift it is below twice the divisor and the WIDTH+1-bit difference
    // cannot overflow; its MSB is therefore a valid sign bit.
    logic [2*WIDTH:0]       shifted;
    logic [WIDTH:0]         trial;
    assign shifted = work_reg << 1;
    assign trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};

    logic [WIDTH-1:0]       q_fix;
    logic [WIDTH-1:0]       r_fix;
    assign q_fix = neg_q_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
    assign r_fix = neg_r_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DivFree;
            cnt_reg     <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DivResultNotReady;
        end else begin
            case (state_reg)
                DivFree: begin
                    result_reg <= '0;
                    ready_reg  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        work_reg    <= {{(WIDTH+1){1'b0}}, abs1};
                        divisor_reg <= abs2;
                        neg_q_reg   <= sign1 ^ sign2;
                        neg_r_reg   <= sign1;
                        cnt_reg     <= '0;
                        state_reg   <= (abs2 == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    result_reg <= '0;
                    ready_reg  <= DivResultReady;
                    state_reg  <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        result_reg <= '0;
                        ready_reg  <= DivResultNotReady;
                        state_reg  <= DivFree;
                    end else if (cnt_reg == CNT_W'(WIDTH)) begin
                        result_reg <= {r_fix, q_fix};
                        ready_reg  <= DivResultReady;
                        state_reg  <= DivEnd;
                    end else begin
                        if (trial[WIDTH]) begin
                            work_reg <= shifted;
                        end else begin
                            work_reg <= {trial, shifted[WIDTH-1:1], 1'b1};
                        end
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DivEnd: begin
                    if (annul_i || start_i == DivStop) begin
                        result_reg <= '0;
                        ready_reg  <= DivResultNotReady;
                        state_reg  <= DivFree;
                    end
                end
                default: begin
                    result_reg <= '0;
                    ready_reg  <= DivResultNotReady;
                    state_reg  <= DivFree;
                end
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // Reference quotient/remainder via 64-bit arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: a divide is a countdown of busy cycles after
    // which the precomputed answer appears and stays until start drops.
    int          m_cnt   = 0;
    bit          m_dz    = 0;
    logic        m_ready = 1'b0;
    logic [63:0] m_res   = '0;
    logic [63:0] m_pend  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else if (m_ready) begin
            if (!start_i || annul_i) begin
                m_ready <= 1'b0;
                m_res   <= '0;
            end
        end else if (m_cnt > 0) begin
            if (annul_i && !m_dz) begin
                m_cnt <= 0;
            end else if (m_cnt == 1) begin
                m_cnt   <= 0;
                m_ready <= 1'b1;
                m_res   <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (start_i && !annul_i) begin
            m_pend <= ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_dz   <= (opdata2_i == 32'd0);
            m_cnt  <= (opdata2_i == 32'd0) ? 1 : 33;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (ready_o !== m_ready || result_o !== m_res) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t: ready_o=%0b result_o=%h, model wants ready=%0b result=%h",
                         $time, ready_o, result_o, m_ready, m_res);
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int exp_lat,
                           input bit scramble);
        int lat;
        check_lit({"model ", name}, ref_div(s, a, b), {er, eq});
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat = 0;
        while (!ready_o && lat < 60) begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 5) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'd0;
                signed_div_i = ~s;
            end
        end
        check_lit({name, " latency"}, 64'(lat), 64'(exp_lat));
        check_lit({name, " result"}, result_o, {er, eq});
        repeat (3) @(negedge clk);
        check_lit({name, " hold"}, {result_o[63:1], ready_o}, {er, eq[31:1], 1'b1});
        check_lit({name, " hold_q0"}, 64'(result_o[0]), 64'(eq[0]));
        start_i = 1'b0;
        @(negedge clk);
        check_lit({name, " release"}, {63'd0, ready_o} | result_o, 64'd0);
        $display("div %-8s s=%0b a=%h b=%h -> q=%h r=%h lat=%0d", name, s, a, b,
                 eq, er, lat);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;
        check_lit("reset result", result_o, 64'd0);
        check_lit("reset ready", 64'(ready_o), 64'd0);

        run_div("u100/7", 0, 32'd100,        32'd7,          32'd14,         32'd2,          34, 0);
        run_div("s-7/2",  1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, 0);
        run_div("u-7/2",  0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          34, 0);
        run_div("s7/-2",  1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34, 0);
        run_div("div0",   0, 32'd55,         32'd0,          32'd0,          32'd0,          2,  0);
        run_div("sovf",   1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34, 0);
        run_div("u5/9",   0, 32'd5,          32'd9,          32'd0,          32'd5,          34, 0);
        run_div("u1000/7",0, 32'd1000,       32'd7,          32'd142,        32'd6,          34, 1);

        // Annul on the tenth edge of 1000/3, then a fresh 9/3.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        check_lit("annul ready", 64'(ready_o), 64'd0);
        repeat (35) @(negedge clk);
        check_lit("annul stays idle", {63'd0, ready_o} | result_o, 64'd0);
        $display("div annul    1000/3 annulled at E10");
        run_div("u9/3",   0, 32'd9,          32'd3,          32'd3,          32'd0,          34, 0);

        // Reset on the fifth edge of an in-flight divide.
        @(negedge clk);
        opdata1_i = 32'd20;
        opdata2_i = 32'd4;
        start_i = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        check_lit("midrst ready", 64'(ready_o), 64'd0);
        check_lit("midrst result", result_o, 64'd0);
        repeat (35) @(negedge clk);
        check_lit("midrst idle", {63'd0, ready_o} | result_o, 64'd0);
        $display("div reset    20/4 reset at E5");

        run_div("u20/4",  0, 32'd20,         32'd4,          32'd5,          32'd0,          34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
